// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: round-robin arbiter and round sequencer for one shared ASCON datapath.
// Optional feature macro: ASCON_PERM_ERR_EN (illegal round counts answered with rsp_err). Rev 1.0
`default_nettype none

module ascon_perm_scheduler #(
  parameter int STATE_W    = 320,
  parameter int MAX_ROUNDS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_rounds,
  input  logic [2*STATE_W-1:0] req_state,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [STATE_W-1:0]   rsp_state,
  output logic                 rsp_err,
  output logic                 dp_load,
  output logic                 dp_en,
  output logic [7:0]           dp_rcon,
  output logic [STATE_W-1:0]   dp_din,
  input  logic [STATE_W-1:0]   dp_state
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               prio;
  logic               id;
  logic [3:0]         rounds;
  logic [3:0]         rnd;
  logic               win;
  logic [3:0]         win_rounds;
  logic [3:0]         eff_rounds;
  logic               win_legal;
  logic               win_bad;
  logic               accept;
  logic [STATE_W-1:0] win_state;
`ifdef ASCON_PERM_ERR_EN
  logic               err;
  logic [STATE_W-1:0] lat_state;
`endif

  function automatic logic [7:0] rcon_of(input logic [3:0] k);
    return {4'hF - k, k};
  endfunction

  // When both request, the one not served last wins.
  always_comb begin
    if (req_valid == 2'b11) win = prio;
    else                    win = req_valid[1];
  end

  assign win_rounds = win ? req_rounds[7:4] : req_rounds[3:0];
  assign win_state  = win ? req_state[2*STATE_W-1:STATE_W] : req_state[STATE_W-1:0];
  assign win_legal  = (win_rounds != 4'd0) && (win_rounds <= MAX_R);
  assign eff_rounds = win_legal ? win_rounds : MAX_R;
  assign accept     = (state == IDLE) && (req_valid != 2'b00);
`ifdef ASCON_PERM_ERR_EN
  assign win_bad    = !win_legal;
`else
  assign win_bad    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_state = '0;
    rsp_err   = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    dp_rcon   = 8'h00;
    dp_din    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready = win ? 2'b10 : 2'b01;
          if (win_bad) begin
            state_nxt = DONE;
          end else begin
            dp_load   = 1'b1;
            dp_en     = 1'b1;
            dp_din    = win_state;
            dp_rcon   = rcon_of(MAX_R - eff_rounds);
            state_nxt = (eff_rounds == 4'd1) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        dp_en   = 1'b1;
        dp_rcon = rcon_of(MAX_R - rounds + rnd);
        if (rnd == rounds - 4'd1) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id;
`ifdef ASCON_PERM_ERR_EN
        rsp_err   = err;
        rsp_state = err ? lat_state : dp_state;
`else
        rsp_state = dp_state;
`endif
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      id        <= 1'b0;
      rounds    <= 4'd0;
      rnd       <= 4'd0;
`ifdef ASCON_PERM_ERR_EN
      err       <= 1'b0;
      lat_state <= '0;
`endif
    end else begin
      if (accept) begin
        id        <= win;
        rounds    <= eff_rounds;
        rnd       <= 4'd1;
`ifdef ASCON_PERM_ERR_EN
        err       <= win_bad;
        lat_state <= win_state;
`endif
      end else if (state == RUN) begin
        rnd <= rnd + 4'd1;
      end
      if (state == DONE && rsp_ready) prio <= ~id;
    end
  end

endmodule

`default_nettype wire
